// File: rtl/byte_capture_fifo.sv
// byte_capture_fifo
// Input stage for the byte delay line. Synchronises the switch byte and the
// capture button, debounces the button and stores one byte per press in a
// small first-word fall-through FIFO with a valid/ready output handshake.
module byte_capture_fifo #(
  parameter  int DEPTH      = 8,
  parameter  int DEB_CYCLES = 4,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    data_in,
  input  logic          strobe_in,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          clear_ovf
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [7:0]    DEB_MAX  = 8'(DEB_CYCLES);
  localparam logic [7:0]    DEB_LAST = 8'(DEB_CYCLES - 1);

  // Synchroniser stages
  logic [7:0]    s1_data;
  logic [7:0]    s2_data;
  logic          s1_strobe;
  logic          s2_strobe;

  // Debounce state
  logic [7:0]    deb;
  logic          capture;

  // FIFO state
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;
  logic          not_empty;
  logic          is_full;

  // Two-flop synchronisers for the switch byte and the button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data   <= 8'h00;
      s2_data   <= 8'h00;
      s1_strobe <= 1'b0;
      s2_strobe <= 1'b0;
    end else begin
      s1_data   <= data_in;
      s2_data   <= s1_data;
      s1_strobe <= strobe_in;
      s2_strobe <= s1_strobe;
    end
  end

  // Debounce counter: clears while the button is low, saturates while held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb <= 8'h00;
    end else if (!s2_strobe) begin
      deb <= 8'h00;
    end else if (deb < DEB_MAX) begin
      deb <= deb + 8'd1;
    end
  end

  // The capture pulse fires once, on the cycle the counter reaches its last
  // step; saturation keeps a held button from re-firing.
  assign capture   = s2_strobe && (deb == DEB_LAST);

  assign not_empty = (count != '0);
  assign is_full   = (count == FULL);
  assign pop       = not_empty && out_ready;
  assign push      = capture && (!is_full || pop);
  assign drop      = capture && is_full && !pop;

  // Storage array, written on push; intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s2_data;
    end
  end

  // Write pointer wraps naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Read pointer advances on each accepted output byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy register; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop on the same edge as a clear keeps it set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Fall-through head: depends only on registered state, never on out_ready
  always_comb begin
    out_valid = not_empty;
    out_data  = 8'h00;
    if (not_empty) begin
      out_data = mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_byte_capture_fifo.sv
// Testbench for byte_capture_fifo: directed scenarios plus randomized presses,
// checked every cycle against a queue-based reference model.
module tb_byte_capture_fifo;

  localparam int DEPTH = 8;
  localparam int DEB   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    data_in = 8'h00;
  logic          strobe_in = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clear_ovf = 1'b0;

  byte_capture_fifo #(.DEPTH(DEPTH), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .strobe_in (strobe_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q [$];
  bit         m_ovf = 1'b0;
  int         edge_n = 0;
  int         cap_edge = -1;
  logic [7:0] cap_byte = 8'h00;
  bit         rand_ready = 1'b0;
  bit         rand_clear = 1'b0;
  bit         pop_on_cap = 1'b0;
  bit         clr_on_cap = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    else n_pass++;
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock edge: set per-cycle controls, advance the model, compare.
  task automatic tick();
    bit cap, pop;
    int sz;
    logic [7:0] dummy;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    if (rand_clear) clear_ovf = ($urandom_range(0, 15) == 0);
    if (pop_on_cap) out_ready = (edge_n + 1 == cap_edge);
    if (clr_on_cap) clear_ovf = (edge_n + 1 == cap_edge);
    @(posedge clk);
    edge_n++;
    sz  = q.size();
    cap = (edge_n == cap_edge);
    pop = (sz > 0) && out_ready;
    if (pop) dummy = q.pop_front();
    if (cap && (sz < DEPTH || pop)) q.push_back(cap_byte);
    if (cap && sz == DEPTH && !pop) m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;
    #1;
    check_outputs();
  endtask

  // A press: byte set up early, button high for len edges, then low for gap.
  // Capture happens DEB+1 edges after the first high sample if len >= DEB.
  task automatic press(input logic [7:0] b, input int len, input int gap);
    data_in = b;
    repeat (3) tick();
    strobe_in = 1'b1;
    cap_byte  = b;
    cap_edge  = (len >= DEB) ? edge_n + 2 + DEB : -1;
    $display("press byte=%02h len=%0d capture_edge=%0d", b, len, cap_edge);
    repeat (len) tick();
    strobe_in = 1'b0;
    repeat (gap) tick();
  endtask

  // Drain with out_ready high; returns the last byte seen before the final pop
  task automatic drain(output logic [7:0] last);
    last = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (out_valid) last = out_data;
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(count), 32'h0);
  endtask

  logic [7:0] last_b;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;

    // Single capture of A5, button held 20 cycles
    press(8'hA5, 20, 10);
    check("single_count", 32'(count), 32'h1);
    check("single_data", 32'(out_data), 32'hA5);
    drain(last_b);

    // Glitch shorter than the debounce window
    press(8'h3C, DEB - 1, 10);
    check("glitch_count", 32'(count), 32'h0);

    // Fill and overflow
    for (int i = 1; i <= 9; i++) press(8'(i), DEB + 1, DEB + 3);
    check("fill_count", 32'(count), 32'(DEPTH));
    check("fill_ovf", 32'(overflow), 32'h1);
    drain(last_b);
    check("fill_last", 32'(last_b), 32'h08);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) press(8'($urandom), DEB + 1, DEB + 3);
    pop_on_cap = 1'b1;
    press(8'h55, DEB + 2, DEB + 3);
    pop_on_cap = 1'b0;
    out_ready  = 1'b0;
    check("simul_count", 32'(count), 32'(DEPTH));
    check("simul_ovf", 32'(overflow), 32'h0);
    drain(last_b);
    check("simul_last", 32'(last_b), 32'h55);

    // Overflow set wins over clear on the same edge
    for (int i = 0; i < DEPTH; i++) press(8'($urandom), DEB + 1, DEB + 3);
    clr_on_cap = 1'b1;
    press(8'hEE, DEB, DEB + 3);
    clr_on_cap = 1'b0;
    clear_ovf  = 1'b0;
    check("prio_ovf", 32'(overflow), 32'h1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("prio_clear", 32'(overflow), 32'h0);
    drain(last_b);

    // Randomized presses with random ready and occasional clears
    rand_ready = 1'b1;
    rand_clear = 1'b1;
    for (int i = 0; i < 40; i++)
      press(8'($urandom), $urandom_range(1, 2 * DEB), DEB + 3 + $urandom_range(0, 3));
    rand_ready = 1'b0;
    rand_clear = 1'b0;
    clear_ovf  = 1'b0;
    drain(last_b);

    // Asynchronous reset mid-drain with five entries held
    for (int i = 0; i < 7; i++) press(8'($urandom), DEB + 1, DEB + 3);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check("pre_rst_count", 32'(count), 32'h5);
    strobe_in = 1'b1;
    data_in   = 8'hC3;
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_count", 32'(count), 32'h0);
    check("arst_data", 32'(out_data), 32'h0);
    check("arst_ovf", 32'(overflow), 32'h0);
    q.delete();
    m_ovf = 1'b0;
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
    reset    = 1'b0;
    cap_byte = 8'hC3;
    cap_edge = edge_n + 2 + DEB;
    $display("reset released, button held, capture_edge=%0d", cap_edge);
    repeat (DEB + 1) tick();
    check("rel_before", 32'(count), 32'h0);
    tick();
    check("rel_push", 32'(count), 32'h1);
    check("rel_data", 32'(out_data), 32'hC3);
    repeat (5) tick();
    strobe_in = 1'b0;
    repeat (5) tick();
    drain(last_b);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
